spi_master_param: RTL and testbench

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

---
 rtl/spi_master_param_if.sv | 35 +++
 rtl/spi_master_param.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_master_param.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_param_if.sv
// Command/response handshake and SPI pins of the parameterised SPI master.
// The master modport is the controller's view; the slave modport is the
// view of whatever drives commands and models the remote SPI device.
interface spi_master_param_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4
);
  localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [SEL_W-1:0]  tx_ss_sel;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic              abort;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              spi_MISO;
  logic              spi_MOSI;
  logic              spi_SCLK;
  logic [NUM_SS-1:0] spi_SS_n;

  modport master (
    input  tx_valid, tx_data, tx_ss_sel, cpol, cpha, lsb_first, abort, spi_MISO,
    output tx_ready, rx_valid, rx_data, busy, spi_MOSI, spi_SCLK, spi_SS_n
  );

  modport slave (
    output tx_valid, tx_data, tx_ss_sel, cpol, cpha, lsb_first, abort, spi_MISO,
    input  tx_ready, rx_valid, rx_data, busy, spi_MOSI, spi_SCLK, spi_SS_n
  );
endinterface

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one command in, one DATA_W-bit full-duplex
// transfer out, with per-transfer CPOL/CPHA/bit order and cancel.
// All pin-level outputs come straight from flops.
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 4,
  parameter int CLK_DIV = 4
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  spi_master_param_if.master bus
);
  localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, XFER = 2'd2, HOLD = 2'd3} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic                rx_valid_q, rx_valid_d;
  logic                mosi_q, mosi_d, sclk_q, sclk_d;
  logic [NUM_SS-1:0]   ss_n_q, ss_n_d;

  logic [EDGE_W-1:0]   edge_num_s;
  logic [EDGE_W-1:0]   bit_idx_s;
  logic                odd_s, shift_edge_s, sample_edge_s, div_last_s;

  // Bit number idx of the word in transmission order (0 = first on the wire).
  function automatic logic pick_bit(input logic [DATA_W-1:0] word,
                                    input logic [EDGE_W-1:0] idx,
                                    input logic lsb);
    logic res;
    res = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (int'(idx) == i) begin
        if (lsb) res = word[i];
        else     res = word[DATA_W-1-i];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // One-cold select pattern; an out-of-range index selects nobody.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_SS-1:0] res;
    res = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(sel) == i) res[i] = 1'b0;
      else                res[i] = 1'b1;
    end
    return res;
  endfunction

  // Edge bookkeeping: edge_num_s is the SCLK edge produced when the divider wraps.
  assign edge_num_s    = edge_q + EDGE_W'(1);
  assign odd_s         = edge_num_s[0];
  assign bit_idx_s     = edge_num_s >> 1;
  assign shift_edge_s  = cpha_q ? odd_s : (!odd_s && (edge_num_s != LAST_EDGE));
  assign sample_edge_s = cpha_q ? !odd_s : odd_s;
  assign div_last_s    = (div_q == DIV_LAST);

  assign bus.tx_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.spi_MOSI = mosi_q;
  assign bus.spi_SCLK = sclk_q;
  assign bus.spi_SS_n = ss_n_q;

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic; abort beats any divider wrap in the busy states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.tx_valid) state_d = SETUP;
        else              state_d = IDLE;
      end
      SETUP: begin
        if (bus.abort)       state_d = IDLE;
        else if (div_last_s) state_d = XFER;
        else                 state_d = SETUP;
      end
      XFER: begin
        if (bus.abort)                                     state_d = IDLE;
        else if (div_last_s && (edge_num_s == LAST_EDGE))  state_d = HOLD;
        else                                               state_d = XFER;
      end
      HOLD: begin
        if (bus.abort)       state_d = IDLE;
        else if (div_last_s) state_d = IDLE;
        else                 state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: latch command, generate edges, shift data.
  always_comb begin
    div_d      = div_q;
    edge_d     = edge_q;
    word_d     = word_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    rx_valid_d = 1'b0;
    mosi_d     = mosi_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    case (state_q)
      IDLE: begin
        if (bus.tx_valid) begin
          word_d  = bus.tx_data;
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          lsb_d   = bus.lsb_first;
          div_d   = '0;
          edge_d  = '0;
          rx_sh_d = '0;
          sclk_d  = bus.cpol;
          ss_n_d  = ss_decode(bus.tx_ss_sel);
          // CPHA=0 needs the first bit on the wire before the first edge.
          if (bus.cpha) mosi_d = 1'b0;
          else          mosi_d = pick_bit(bus.tx_data, EDGE_W'(0), bus.lsb_first);
        end else begin
          sclk_d = cpol_q;
          ss_n_d = '1;
        end
      end
      SETUP, XFER: begin
        if (bus.abort) begin
          div_d  = '0;
          sclk_d = cpol_q;
          ss_n_d = '1;
        end else if (div_last_s) begin
          div_d  = '0;
          edge_d = edge_num_s;
          sclk_d = ~sclk_q;
          if (shift_edge_s) mosi_d = pick_bit(word_q, bit_idx_s, lsb_q);
          else              mosi_d = mosi_q;
          if (sample_edge_s) begin
            if (lsb_q) rx_sh_d = {bus.spi_MISO, rx_sh_q[DATA_W-1:1]};
            else       rx_sh_d = {rx_sh_q[DATA_W-2:0], bus.spi_MISO};
          end else begin
            rx_sh_d = rx_sh_q;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (bus.abort) begin
          div_d  = '0;
          sclk_d = cpol_q;
          ss_n_d = '1;
        end else if (div_last_s) begin
          div_d      = '0;
          ss_n_d     = '1;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        div_d  = '0;
        sclk_d = cpol_q;
        ss_n_d = '1;
      end
    endcase
  end

  // Datapath and pin registers; reset releases every select immediately.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_q      <= '0;
      edge_q     <= '0;
      word_q     <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      mosi_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= '1;
    end else begin
      div_q      <= div_d;
      edge_q     <= edge_d;
      word_q     <= word_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      rx_valid_q <= rx_valid_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
    end
  end
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: a cycle-indexed reference model predicts
// every pin from the transfer's offset since acceptance, plus literal
// checks for the classic scenarios.
module tb_spi_master_param;
  localparam int DW  = 8;
  localparam int NSS = 5;   // lets a 3-bit select encode out-of-range index 5
  localparam int H   = 4;
  localparam int SW  = 3;
  localparam int D   = 1 + H * (2 * DW + 1);  // accept -> rx_valid distance

  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b1;
  always #5 clk_clk = ~clk_clk;

  spi_master_param_if #(.DATA_W(DW), .NUM_SS(NSS)) bus();

  spi_master_param #(.DATA_W(DW), .NUM_SS(NSS), .CLK_DIV(H)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  // reference model state for the transfer in flight
  bit          act = 1'b0;
  int          a = 0;
  int          ab_at = -1;
  logic [DW-1:0] x_word, s_word;
  int          x_sel;
  bit          x_cpol, x_cpha, x_lsb, x_loop = 1'b0;
  logic [DW-1:0] prev_rx = '0;
  bit          last_cpol = 1'b0;
  bit          miso_drv = 1'b0;

  // observation helpers for literal checks
  int            rise_cnt = 0;
  int            rxv_cyc = -1;
  logic [DW-1:0] rise_vec = '0, fall_vec = '0;
  logic          sclk_prev = 1'b0;

  assign bus.spi_MISO = x_loop ? bus.spi_MOSI : miso_drv;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // j-th bit on the wire of word w
  function automatic logic bit_of(input logic [DW-1:0] w, input int j, input bit lsb);
    logic [DW-1:0] s;
    s = w >> (lsb ? j : (DW - 1 - j));
    return s[0];
  endfunction

  // SCLK edges already visible at offset o after acceptance
  function automatic int toggles(input int o);
    int t;
    if (o < 1) t = 0;
    else t = (o - 1) / H;
    if (t > 2 * DW) t = 2 * DW;
    return t;
  endfunction

  function automatic logic [NSS-1:0] exp_ss(input int sel);
    logic [NSS-1:0] one;
    one = 1;
    if (sel < NSS) return ~(one << sel);
    return '1;
  endfunction

  task automatic check_cycle();
    int o, t, j;
    logic [NSS-1:0] e_ss;
    bit e_busy, e_rv, e_sclk;
    logic [DW-1:0] e_rx;
    e_ss = '1; e_busy = 1'b0; e_rv = 1'b0; e_sclk = last_cpol; e_rx = prev_rx;
    if (act) begin
      o = cyc - a;
      if (ab_at >= 0 && o == ab_at + 1) begin
        act = 1'b0; last_cpol = x_cpol; e_sclk = x_cpol;
      end else if (o == D) begin
        e_rv = 1'b1; e_rx = x_loop ? x_word : s_word; prev_rx = e_rx;
        act = 1'b0; last_cpol = x_cpol; e_sclk = x_cpol;
      end else begin
        t = toggles(o);
        e_busy = 1'b1;
        e_ss = exp_ss(x_sel);
        e_sclk = x_cpol ^ t[0];
        if (!x_cpha) begin
          j = t / 2; if (j > DW - 1) j = DW - 1;
          chk("mosi", bus.spi_MOSI, bit_of(x_word, j, x_lsb));
        end else if (t >= 1) begin
          chk("mosi", bus.spi_MOSI, bit_of(x_word, (t - 1) / 2, x_lsb));
        end
      end
    end
    chk("ss_n", bus.spi_SS_n, e_ss);
    chk("sclk", bus.spi_SCLK, e_sclk);
    chk("tx_ready", bus.tx_ready, !e_busy);
    chk("busy", bus.busy, e_busy);
    chk("rx_valid", bus.rx_valid, e_rv);
    chk("rx_data", bus.rx_data, e_rx);
  endtask

  // remote device: presents its word bit by bit, plus abort control
  task automatic drive_slave();
    int o, t, j;
    if (act) begin
      o = cyc - a; t = toggles(o);
      if (!x_cpha) begin j = t / 2; if (j > DW - 1) j = DW - 1; end
      else if (t == 0) j = 0;
      else j = (t - 1) / 2;
      miso_drv = bit_of(s_word, j, x_lsb);
      bus.abort = (ab_at >= 0 && o == ab_at);
    end else begin
      miso_drv = 1'($urandom_range(0, 1));
      bus.abort = 1'($urandom_range(0, 1));  // must be ignored while idle
    end
  endtask

  task automatic tick();
    @(posedge clk_clk); cyc++;
    @(negedge clk_clk);
    check_cycle();
    if (bus.spi_SCLK !== sclk_prev) begin
      if (bus.spi_SCLK) begin rise_cnt++; rise_vec = {rise_vec[DW-2:0], bus.spi_MOSI}; end
      else fall_vec = {fall_vec[DW-2:0], bus.spi_MOSI};
    end
    sclk_prev = bus.spi_SCLK;
    if (bus.rx_valid === 1'b1) rxv_cyc = cyc;
    drive_slave();
  endtask

  task automatic start_xfer(input logic [DW-1:0] w, input int sel, input bit cp, input bit ch,
                            input bit lsb, input bit loop, input logic [DW-1:0] sw, input int ab);
    bus.tx_data = w; bus.tx_ss_sel = SW'(sel); bus.cpol = cp; bus.cpha = ch;
    bus.lsb_first = lsb; bus.tx_valid = 1'b1;
    x_word = w; x_sel = sel; x_cpol = cp; x_cpha = ch; x_lsb = lsb; x_loop = loop;
    s_word = sw; ab_at = ab; a = cyc; act = 1'b1;
    rise_cnt = 0; rise_vec = '0; fall_vec = '0; rxv_cyc = -1; sclk_prev = cp;
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_data = DW'($urandom); bus.tx_ss_sel = SW'($urandom);
    bus.cpol = 1'($urandom); bus.cpha = 1'($urandom); bus.lsb_first = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (act && n < 4 * D) begin tick(); n++; end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ss_n"}, bus.spi_SS_n, {NSS{1'b1}});
    chk({tag, "_sclk"}, bus.spi_SCLK, 1'b0);
    chk({tag, "_mosi"}, bus.spi_MOSI, 1'b0);
    chk({tag, "_tx_ready"}, bus.tx_ready, 1'b1);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
    chk({tag, "_rx_data"}, bus.rx_data, '0);
  endtask

  initial begin
    bus.tx_valid = 1'b0; bus.tx_data = '0; bus.tx_ss_sel = '0; bus.cpol = 1'b0;
    bus.cpha = 1'b0; bus.lsb_first = 1'b0; bus.abort = 1'b0;
    #1 reset_reset_n = 1'b0;
    #2 chk_reset_vals("reset");
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;

    // mode 0, MSB first, loopback, 0xA5
    start_xfer(8'hA5, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, -1);
    wait_idle();
    chk("m0_rising_edges", rise_cnt, 8);
    chk("m0_rx_latency", rxv_cyc - a, 69);
    chk("m0_rx_data", bus.rx_data, 8'hA5);

    // mode 3, 0x3C out, 0xC3 in
    start_xfer(8'h3C, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, -1);
    chk("m3_sclk_idle", bus.spi_SCLK, 1'b1);
    wait_idle();
    chk("m3_mosi_falling", fall_vec, 8'b0011_1100);
    chk("m3_rx_data", bus.rx_data, 8'hC3);

    // LSB first, 0x01
    start_xfer(8'h01, 3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6E, -1);
    wait_idle();
    chk("lsb_mosi_bits", rise_vec, 8'b1000_0000);

    // in-range then out-of-range select, back to back
    start_xfer(8'h5A, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h96, -1);
    repeat (10) tick();
    chk("sel2_ss_n", bus.spi_SS_n, 5'b11011);
    wait_idle();
    chk("sel2_rx_valid", rxv_cyc - a, 69);
    start_xfer(8'hC7, 5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h2B, -1);
    repeat (10) tick();
    chk("sel5_ss_n", bus.spi_SS_n, 5'b11111);
    wait_idle();
    chk("sel5_rx_valid", rxv_cyc - a, 69);

    // abort right after edge 5
    start_xfer(8'hF0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0F, 1 + 5 * H);
    wait_idle();
    chk("abort_ss_n", bus.spi_SS_n, 5'b11111);
    chk("abort_sclk", bus.spi_SCLK, 1'b1);
    chk("abort_tx_ready", bus.tx_ready, 1'b1);
    chk("abort_no_rx_valid", rxv_cyc, -1);

    // abort coincident with the rx_valid condition
    start_xfer(8'h81, 4, 1'b0, 1'b1, 1'b1, 1'b0, 8'h7E, D - 1);
    repeat (3) tick();
    wait_idle();
    tick();
    chk("late_abort_no_rx_valid", rxv_cyc, -1);

    // reset in the middle of a transfer
    start_xfer(8'h99, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44, -1);
    repeat (30) tick();
    #1 reset_reset_n = 1'b0;
    #1 chk_reset_vals("mid_reset");
    act = 1'b0; prev_rx = '0; last_cpol = 1'b0; bus.abort = 1'b0;
    repeat (3) tick();
    reset_reset_n = 1'b1;
    tick();
    start_xfer(8'h3E, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, -1);
    wait_idle();
    chk("post_reset_rx_data", bus.rx_data, 8'h3E);

    // randomized transfers
    for (int k = 0; k < 30; k++) begin
      int ab;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, D - 1)) : -1;
      start_xfer(DW'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), DW'($urandom), ab);
      wait_idle();
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
